// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : Definitions shared by the bit-serial adder and its full-adder cell.
//           Holds the controller state encoding and the default operand width.
//
// Contents:
//   state_t            - controller state (IDLE, RUN, DONE)
//   SERIAL_ADDER_WIDTH - default operand / result width in bits
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // Default operand width; any value from 1 to 32 is legal.
  localparam int SERIAL_ADDER_WIDTH = 8;

  // Controller states.
  //   IDLE : waiting for start
  //   RUN  : one operand bit pair is consumed per clock
  //   DONE : result valid, done asserted for this single cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
//
// Purpose : Combinational one-bit full adder. It is the only arithmetic element
//           of the serial adder; every result bit and carry passes through it.
//
// Ports   :
//   a   in  1  operand A bit
//   b   in  1  operand B bit
//   ci  in  1  carry in
//   s   out 1  sum bit      (a ^ b ^ ci)
//   co  out 1  carry out    (majority of a, b, ci)
// -----------------------------------------------------------------------------
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  // Generate when both operand bits are set, propagate an incoming carry
  // when exactly one of them is set.
  assign co       = (a & b) | (ci & half_sum);

endmodule : serial_fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Purpose : Bit-serial adder. Sums two WIDTH-bit operands one bit per clock,
//           LSB first, using a single full-adder cell and a registered carry.
//           Handshake is start / busy / done; the result is held in sum/cout
//           until the next operation completes.
//
//           {cout, sum} = a + b + cin   (modulo 2^(WIDTH+1))
//
// Optional feature (compile-time macro SERIAL_ADDER_SUB_EN):
//           Adds input port "sub". When sub=1 on the accepting edge the B
//           register is loaded with ~b and the carry with 1 (cin ignored),
//           giving sum = a - b mod 2^WIDTH and cout = 1 when no borrow.
//           Without the macro the block only adds and has no sub port.
//
// Parameters:
//   WIDTH   operand/result width, 1..32 (default SERIAL_ADDER_WIDTH = 8)
//
// Ports   :
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset, clears all state
//   start  in   1      request; only honoured in IDLE or DONE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry in, sampled on the accepting edge
//   sub    in   1      subtract select (SERIAL_ADDER_SUB_EN builds only)
//   busy   out  1      high while an operation is running
//   done   out  1      single-cycle pulse when the result is updated
//   sum    out  WIDTH  registered result
//   cout   out  1      registered final carry
//
// Timing  : the accepting edge is edge 0; bit k is processed on edge k+1, so
//           the result lands on edge WIDTH and done is high for the following
//           cycle. A start seen in DONE is accepted on the next edge, so
//           back-to-back operations take WIDTH+1 cycles each.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must be able to hold 0..WIDTH-1; sized as log2(WIDTH+1) so a
  // WIDTH of 1 still gets a one-bit counter.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;     // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_sh_reg;     // operand B (or ~B when subtracting)
  logic [WIDTH-1:0] res_sh_reg;   // partial result, filled from the MSB down
  logic             carry_reg;    // carry between successive bit positions
  logic [CNT_W-1:0] cnt_reg;      // index of the bit processed on the next edge
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_sh_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             last_bit;

  // The single full-adder cell: current LSBs of both operand registers and
  // the stored carry.
  serial_fa_cell u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result shift register input: every bit moves one place toward the LSB and
  // the new sum bit enters at the MSB. After WIDTH shifts the first computed
  // bit has reached bit 0, so the register holds the result in natural order.
  // Written bitwise so that WIDTH=1 needs no special casing.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign res_sh_next[gi] = res_sh_reg[gi+1];
    end
  endgenerate
  assign res_sh_next[WIDTH-1] = fa_s;

  // Operand B and initial carry as loaded on the accepting edge. Subtraction
  // is a + ~b + 1, so only the load path differs from addition.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign last_bit = (cnt_reg == LAST_BIT);

  // ---------------------------------------------------------------------------
  // Controller and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        // IDLE and DONE share the accept path, which is what lets a start in
        // DONE begin the next operation without a dead cycle.
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b_load;
            carry_reg  <= carry_load;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end

        // start is not looked at here, so a request during RUN cannot disturb
        // the operands in flight.
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_sh_next;
          carry_reg  <= fa_co;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (last_bit) begin
            // The final bit is consumed on this edge, so the result is taken
            // from the shift-register input rather than its (stale) output.
            sum_reg   <= res_sh_next;
            cout_reg  <= fa_co;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. Three instances share one clock and reset:
// WIDTH=8 for the handshake/timing scenarios, WIDTH=3 for an exhaustive sweep
// and WIDTH=1 for the minimum-latency case. Inputs are driven and outputs
// sampled 1 time unit after the rising edge. When SERIAL_ADDER_SUB_EN is
// defined the subtract scenarios run as well.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub3, sub1;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // ---------------------------------------------------------------------------
  // Stimulus / observation helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] observed(input int w);
    case (w)
      8:       return {cout8, sum8};
      3:       return {5'd0, cout3, sum3};
      default: return {7'd0, cout1, sum1};
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      8:       return busy8;
      3:       return busy3;
      default: return busy1;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      8:       return done8;
      3:       return done3;
      default: return done1;
    endcase
  endfunction

  // Present a request for one edge (the accepting edge), then drop start.
  task automatic start_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv);
    case (w)
      8: begin start8 = 1'b1; a8 = av;      b8 = bv;      cin8 = cv; end
      3: begin start3 = 1'b1; a3 = av[2:0]; b3 = bv[2:0]; cin3 = cv; end
      default: begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; cin1 = cv; end
    endcase
    tick();
    start8 = 1'b0;
    start3 = 1'b0;
    start1 = 1'b0;
  endtask

  // Samples busy now, then steps until done (bounded). cycles = edges stepped
  // until done was seen, or -1 when the bound expired.
  task automatic wait_done(input int w, output int cycles, output int busy_cycles,
                           output logic [8:0] res);
    cycles      = -1;
    busy_cycles = 0;
    res         = 9'h1ff;
    if (busy_of(w)) busy_cycles++;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (busy_of(w)) busy_cycles++;
      if (done_of(w)) begin
        cycles = n;
        res    = observed(w);
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [10:0] st;
    rst_n = 1'b0;
    #3;
    st = {busy8, done8, cout8, sum8};
    checks++;
    if (st !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8 {busy,done,cout,sum} got %h want 000", st);
    end
    checks++;
    if ({busy3, done3, cout3, sum3, busy1, done1, cout1, sum1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_w3_w1 got %b want all zero",
               {busy3, done3, cout3, sum3, busy1, done1, cout1, sum1});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle {busy,done} got %b want 00", {busy8, done8});
    end
    $display("txn reset: busy=%0b done=%0b sum=%h cout=%0b", busy8, done8, sum8, cout8);
  endtask

  task automatic test_zero();
    int cyc, bcyc;
    logic [8:0] res;
    start_op(8, 8'h00, 8'h00, 1'b0);
    wait_done(8, cyc, bcyc, res);
    $display("txn zero: 00+00+0 -> cout=%0b sum=%h after %0d cycles", res[8], res[7:0], cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", cyc); end
    checks++;
    if (bcyc !== 8) begin errors++; $display("FAIL zero_busy_cycles got %0d want 8", bcyc); end
    checks++;
    if (res !== 9'h000) begin errors++; $display("FAIL zero_result got %h want 000", res); end
    tick();
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL zero_done_single_pulse {busy,done} got %b want 00", {busy8, done8});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    logic [8:0] res;
    start_op(8, 8'hFF, 8'h01, 1'b0);
    wait_done(8, cyc, bcyc, res);
    $display("txn carry: FF+01+0 -> cout=%0b sum=%h after %0d cycles", res[8], res[7:0], cyc);
    checks++;
    if (res !== 9'h100) begin errors++; $display("FAIL carry_result got %h want 100", res); end
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL carry_latency got %0d want 8", cyc); end
    // Still in the DONE cycle: the next request is accepted on the next edge.
    start_op(8, 8'hA5, 8'h5A, 1'b1);
    checks++;
    if ({busy8, done8} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept {busy,done} got %b want 10", {busy8, done8});
    end
    wait_done(8, cyc, bcyc, res);
    $display("txn b2b: A5+5A+1 -> cout=%0b sum=%h after %0d cycles", res[8], res[7:0], cyc);
    checks++;
    if (res !== 9'h100) begin errors++; $display("FAIL b2b_result got %h want 100", res); end
    checks++;
    if (cyc !== 8 || bcyc !== 8) begin
      errors++;
      $display("FAIL b2b_timing cycles %0d busy %0d want 8 8", cyc, bcyc);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int cyc, bcyc;
    logic [8:0] res;
    start_op(8, 8'h12, 8'h34, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if ({cout8, sum8} !== 9'h100) begin
      errors++;
      $display("FAIL hold_during_run {cout,sum} got %h want 100", {cout8, sum8});
    end
    // Fourth RUN cycle carries a competing request.
    start8 = 1'b1;
    a8     = 8'hFF;
    b8     = 8'hFF;
    cin8   = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(8, cyc, bcyc, res);
    $display("txn ignore: 12+34+0 (start FF mid-run) -> cout=%0b sum=%h after %0d more cycles",
             res[8], res[7:0], cyc);
    checks++;
    if (res !== 9'h046) begin errors++; $display("FAIL ignore_result got %h want 046", res); end
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", cyc); end
    tick();
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_no_restart busy got %b want 0", busy8); end
  endtask

  task automatic test_async_reset();
    int cyc, bcyc, seen;
    logic [8:0] res;
    start_op(8, 8'h80, 8'h80, 1'b1);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset {busy,done,cout,sum} got %h want 000",
               {busy8, done8, cout8, sum8});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done8 || busy8) seen++;
    end
    $display("txn abort: reset mid-run, busy/done cycles seen afterwards=%0d", seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen); end
    start_op(8, 8'h01, 8'h01, 1'b0);
    wait_done(8, cyc, bcyc, res);
    $display("txn after_abort: 01+01+0 -> cout=%0b sum=%h after %0d cycles", res[8], res[7:0], cyc);
    checks++;
    if (res !== 9'h002 || cyc !== 8) begin
      errors++;
      $display("FAIL after_abort result %h cycles %0d want 002 8", res, cyc);
    end
    tick();
  endtask

  task automatic test_width3();
    int cyc, bcyc, expv;
    logic [8:0] res;
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          start_op(3, 8'(ai), 8'(bi), 1'(ci));
          wait_done(3, cyc, bcyc, res);
          expv = ai + bi + ci;
          $display("txn w3: %0d+%0d+%0d -> %0d after %0d cycles", ai, bi, ci, res, cyc);
          checks++;
          if (res !== 9'(expv) || cyc !== 3) begin
            errors++;
            $display("FAIL w3_%0d_%0d_%0d result %0d cycles %0d want %0d 3",
                     ai, bi, ci, res, cyc, expv);
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_width1();
    int cyc, bcyc, expv;
    logic [8:0] res;
    for (int k = 0; k < 8; k++) begin
      start_op(1, 8'(k & 1), 8'((k >> 1) & 1), 1'((k >> 2) & 1));
      wait_done(1, cyc, bcyc, res);
      expv = (k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1);
      $display("txn w1: %0d+%0d+%0d -> %0d after %0d cycles",
               k & 1, (k >> 1) & 1, (k >> 2) & 1, res, cyc);
      checks++;
      if (res !== 9'(expv) || cyc !== 1 || bcyc !== 1) begin
        errors++;
        $display("FAIL w1_%0d result %0d cycles %0d busy %0d want %0d 1 1",
                 k, res, cyc, bcyc, expv);
      end
      tick();
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int cyc, bcyc;
    logic [8:0] res;
    sub8 = 1'b1;
    start_op(8, 8'h10, 8'h01, 1'b0);
    wait_done(8, cyc, bcyc, res);
    $display("txn sub: 10-01 -> cout=%0b sum=%h", res[8], res[7:0]);
    checks++;
    if (res !== 9'h10F) begin errors++; $display("FAIL sub_no_borrow got %h want 10f", res); end
    tick();
    start_op(8, 8'h00, 8'h01, 1'b1);
    wait_done(8, cyc, bcyc, res);
    $display("txn sub: 00-01 -> cout=%0b sum=%h", res[8], res[7:0]);
    checks++;
    if (res !== 9'h0FF) begin errors++; $display("FAIL sub_borrow got %h want 0ff", res); end
    sub8 = 1'b0;
    tick();
    start_op(8, 8'h10, 8'h01, 1'b1);
    wait_done(8, cyc, bcyc, res);
    $display("txn sub0: 10+01+1 -> cout=%0b sum=%h", res[8], res[7:0]);
    checks++;
    if (res !== 9'h012) begin errors++; $display("FAIL sub0_add got %h want 012", res); end
    tick();
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub3 = 1'b0; sub1 = 1'b0;
`endif
    test_reset();
    test_zero();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_width3();
    test_width1();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_adder
